// File: rtl/seq_subtractor.sv
// Chunk-serial two's-complement subtractor: Diff = A - B - Bin, CHUNK bits per cycle.
// Optional saturation on signed overflow when SEQ_SUBTRACTOR_SAT_EN is defined.
module seq_subtractor #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH < 2) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("seq_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q;
  logic             am_q, bm_q, brw_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK:0]   chunk;
  logic [WIDTH-1:0] diff_next, fin;
  logic             raw_ovf, last;

  // Operands shift right each cycle; result chunks enter the shadow from the top.
  always_comb begin
    chunk     = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - (CHUNK+1)'(brw_q);
    diff_next = (sh_q >> CHUNK) | (WIDTH'(chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
    raw_ovf   = (am_q ^ bm_q) & (am_q ^ diff_next[WIDTH-1]);
    last      = (cnt_q == CW'(NCHUNK - 1));
`ifdef SEQ_SUBTRACTOR_SAT_EN
    if (raw_ovf) fin = am_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else         fin = diff_next;
`else
    fin = diff_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sh_q      <= '0;
      am_q      <= 1'b0;
      bm_q      <= 1'b0;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      // Results of the last completed operation stay visible.
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= A;
            b_q      <= B;
            am_q     <= A[WIDTH-1];
            bm_q     <= B[WIDTH-1];
            brw_q    <= Bin;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          sh_q  <= diff_next;
          brw_q <= chunk[CHUNK];
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            Diff      <= fin;
            Bout      <= chunk[CHUNK];
            zero      <= (fin == '0);
            neg       <= fin[WIDTH-1];
            ovf       <= raw_ovf;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor against an arithmetic reference model.
module tb_seq_subtractor;

  localparam int W  = 20;
  localparam int CH = 4;
  localparam int NC = W / CH;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready, Bin;
  logic [W-1:0] A, B;
  logic         in_ready, out_valid, Bout, zero, neg, ovf;
  logic [W-1:0] Diff;
  logic [W+3:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  seq_subtractor #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Bout     (Bout),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  assign obs = {Diff, Bout, zero, neg, ovf};

  // Reference: integer arithmetic, packed as {Diff, Bout, zero, neg, ovf}.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    longint ua, ub, sa, sb, d, sd, lim, tmp;
    logic [W-1:0] fin;
    logic bout, ov;
    lim  = longint'(1) << (W - 1);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = a[W-1] ? ua - 2 * lim : ua;
    sb   = b[W-1] ? ub - 2 * lim : ub;
    d    = ua - ub - longint'(bin);
    bout = (d < 0);
    fin  = d[W-1:0];
    sd   = sa - sb - longint'(bin);
    ov   = (sd < -lim) || (sd >= lim);
`ifdef SEQ_SUBTRACTOR_SAT_EN
    if (ov) begin
      tmp = (sd < -lim) ? lim : lim - 1;
      fin = tmp[W-1:0];
    end
`else
    tmp = 0;
`endif
    return {fin, bout, (fin == '0), fin[W-1], ov};
  endfunction

  // Accepts one operation; returns cycle index of first out_valid and RUN-phase stability.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat, output logic stable);
    logic [W+3:0] snap;
    @(negedge clk);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    snap = obs; stable = 1'b1; lat = 1;
    while (!out_valid && lat < 60) begin
      if (obs !== snap || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: obs=%h ov=%b ir=%b, required obs=0 ov=0 ir=1", obs, out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6] = '{20'h00005, 20'h00000, 20'h80000, 20'h12345, 20'h0000F, 20'h7FFFF};
    logic [W-1:0] vb[6] = '{20'h00003, 20'h00001, 20'h00001, 20'h12344, 20'h0000F, 20'hFFFFF};
    logic         vc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic stable; logic [W+3:0] exp;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], lat, stable);
      exp = model(va[i], vb[i], vc[i]);
      n_checks += 3;
      if (lat != NC + 1) begin
        n_fail++; $display("FAIL directed latency %0d: got %0d, required %0d", i, lat, NC + 1);
      end
      if (!stable) begin
        n_fail++; $display("FAIL directed run-stable %0d: outputs or in_ready moved in RUN", i);
      end
      if (obs !== exp) begin
        n_fail++; $display("FAIL directed result %0d: got %h, required %h", i, obs, exp);
      end
      consume();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed release %0d: ov=%b ir=%b, required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic stable; logic [W+3:0] exp;
    run_op(20'hABCDE, 20'h12345, 1'b1, lat, stable);
    exp = model(20'hABCDE, 20'h12345, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: obs=%h ov=%b ir=%b, required %h 1 0",
                 i, obs, out_valid, in_ready, exp);
      end
    end
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure release: ov=%b ir=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic start_and_reach_c3(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); A = a; B = b; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic watch_no_valid(input string name);
    logic seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL %s: out_valid rose, required 0", name); end
  endtask

  task automatic test_abort_rst();
    int lat; logic stable;
    run_op(20'h00000, 20'h00001, 1'b0, lat, stable);
    consume();
    start_and_reach_c3(20'h55555, 20'h11111);
    rst = 1'b1; #1;
    n_checks++;
    if (obs !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort rst: obs=%h ov=%b ir=%b, required 0 0 1", obs, out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    watch_no_valid("abort rst quiet");
  endtask

  task automatic test_flush();
    int lat; logic stable; logic [W+3:0] prev, exp;
    run_op(20'h00003, 20'h00009, 1'b0, lat, stable);
    consume();
    prev = obs;
    start_and_reach_c3(20'h33333, 20'h22222);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== prev) begin
      n_fail++;
      $display("FAIL flush run: obs=%h ov=%b ir=%b, required %h 0 1", obs, out_valid, in_ready, prev);
    end
    watch_no_valid("flush quiet");
    run_op(20'h40000, 20'hC0000, 1'b0, lat, stable);
    exp = model(20'h40000, 20'hC0000, 1'b0);
    n_checks++;
    if (obs !== exp || lat != NC + 1) begin
      n_fail++; $display("FAIL flush recovery: got %h lat %0d, required %h lat %0d", obs, lat, exp, NC + 1);
    end
    // flush in DONE wins over out_ready and in_valid
    @(negedge clk); flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== exp) begin
      n_fail++;
      $display("FAIL flush done: obs=%h ov=%b ir=%b, required %h 0 1", obs, out_valid, in_ready, exp);
    end
    watch_no_valid("flush done quiet");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int lat; logic stable; logic [W-1:0] a, b; logic c; logic [W+3:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = pick(); b = pick(); c = 1'($urandom);
      if (i % 7 == 0) b = a;
      run_op(a, b, c, lat, stable);
      exp = model(a, b, c);
      n_checks += 2;
      if (lat != NC + 1 || !stable) begin
        n_fail++; $display("FAIL random timing %0d: lat %0d stable %b, required %0d 1", i, lat, stable, NC + 1);
      end
      if (obs !== exp) begin
        n_fail++; $display("FAIL random result %0d: a=%h b=%h c=%b got %h, required %h", i, a, b, c, obs, exp);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int gap; logic [W+3:0] exp;
    // in_valid held high: next accept follows release directly
    @(negedge clk); A = 20'h00010; B = 20'h00001; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    exp = model(20'h00010, 20'h00001, 1'b0);
    @(posedge clk); #1;
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!out_valid && gap < 60);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL b2b first: got %h, required %h", obs, exp); end
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!out_valid && gap < 60);
    n_checks++;
    if (gap != NC + 2) begin
      n_fail++; $display("FAIL b2b spacing: got %0d cycles, required %0d", gap, NC + 2);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort_rst();
    test_flush();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
